// File: rtl/conv_kxk_mc_accum.sv
// Channel-serial KxK convolution engine for a single output filter.
// Each accepted beat carries one KxK window and its weights for one input channel.
// Stage 1 forms the window dot product. Stage 2 accumulates it over C_IN channels.
// After the last channel, stage 2 adds bias, rounds, shifts, applies optional ReLU
// and saturates the result to OUT_BITS.
module conv_kxk_mc_accum #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned K          = 5,
    parameter int unsigned C_IN       = 3,
    parameter int unsigned ACC_BITS   = 32,
    parameter int unsigned OUT_BITS   = 8,
    parameter int unsigned SHIFT_BITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [K*K*DATA_BITS-1:0]      pix,
    input  logic [K*K*DATA_BITS-1:0]      wgt,
    input  logic [ACC_BITS-1:0]           bias,
    input  logic [SHIFT_BITS-1:0]         shift,
    input  logic                          relu_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BITS-1:0]           out_data,
    output logic                          out_sat
);

    localparam int unsigned TAPS      = K * K;
    localparam int unsigned PROD_BITS = 2 * DATA_BITS;
    localparam int unsigned CNT_BITS  = (C_IN > 1) ? $clog2(C_IN) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CH = CNT_BITS'(C_IN - 1);

    // Output range limits, held one bit wider than the accumulator for signed compares.
    localparam logic signed [ACC_BITS:0] SAT_MAX =
        {{(ACC_BITS - OUT_BITS + 2){1'b0}}, {(OUT_BITS - 1){1'b1}}};
    localparam logic signed [ACC_BITS:0] SAT_MIN = ~SAT_MAX;

    logic                        adv;
    logic                        s1_valid_q;
    logic [ACC_BITS-1:0]         psum_q;
    logic [ACC_BITS-1:0]         psum_d;
    logic [CNT_BITS-1:0]         ch_cnt_q;
    logic [ACC_BITS-1:0]         acc_q;
    logic                        last_ch;
    logic                        out_valid_q;
    logic [OUT_BITS-1:0]         out_data_q;
    logic                        out_sat_q;

    logic signed [PROD_BITS-1:0] p_ext;
    logic signed [PROD_BITS-1:0] w_ext;
    logic signed [PROD_BITS-1:0] prod;

    logic [ACC_BITS-1:0]         acc_base;
    logic [ACC_BITS-1:0]         t_sum;
    logic signed [ACC_BITS:0]    t_ext;
    logic signed [ACC_BITS:0]    rnd;
    logic signed [ACC_BITS:0]    r_val;
    logic [OUT_BITS-1:0]         req_data;
    logic                        req_sat;

    // A single advance term stalls the whole pipe while the output is held.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign last_ch   = (ch_cnt_q == LAST_CH);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Window dot product: sign-extend each product to the accumulator width and sum.
    always_comb begin
        psum_d = '0;
        p_ext  = '0;
        w_ext  = '0;
        prod   = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            p_ext  = {{DATA_BITS{pix[i*DATA_BITS + DATA_BITS - 1]}},
                      pix[i*DATA_BITS +: DATA_BITS]};
            w_ext  = {{DATA_BITS{wgt[i*DATA_BITS + DATA_BITS - 1]}},
                      wgt[i*DATA_BITS +: DATA_BITS]};
            prod   = p_ext * w_ext;
            psum_d = psum_d + {{(ACC_BITS - PROD_BITS){prod[PROD_BITS-1]}}, prod};
        end
    end

    // Final-channel requantisation: bias, round-half-up shift, ReLU, saturate.
    always_comb begin
        acc_base = (C_IN == 1) ? '0 : acc_q;
        t_sum    = acc_base + psum_q + bias;
        t_ext    = {t_sum[ACC_BITS-1], t_sum};
        rnd      = '0;
        if (shift != '0) begin
            rnd = (ACC_BITS + 1)'(1) << (shift - SHIFT_BITS'(1));
        end
        // The extra top bit keeps the rounding add from overflowing.
        r_val = (t_ext + rnd) >>> shift;
        if (relu_en && r_val[ACC_BITS]) begin
            r_val = '0;
        end
        req_sat  = 1'b0;
        req_data = r_val[OUT_BITS-1:0];
        if (r_val > SAT_MAX) begin
            req_data = SAT_MAX[OUT_BITS-1:0];
            req_sat  = 1'b1;
        end else if (r_val < SAT_MIN) begin
            req_data = SAT_MIN[OUT_BITS-1:0];
            req_sat  = 1'b1;
        end
    end

    // Stage 1: register the partial sum of each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            psum_q     <= '0;
        end else if (clr) begin
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            psum_q     <= psum_d;
        end
    end

    // Stage 2: accumulate over channels; the channel counter wraps on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_q <= '0;
            acc_q    <= '0;
        end else if (clr) begin
            ch_cnt_q <= '0;
            acc_q    <= '0;
        end else if (adv && s1_valid_q) begin
            if (last_ch) begin
                ch_cnt_q <= '0;
            end else begin
                acc_q    <= (ch_cnt_q == '0) ? psum_q : acc_q + psum_q;
                ch_cnt_q <= ch_cnt_q + CNT_BITS'(1);
            end
        end
    end

    // Output register: load a new result or retire the consumed one.
    // out_data keeps its last value after the result is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            if (s1_valid_q && last_ch && !clr) begin
                out_valid_q <= 1'b1;
                out_data_q  <= req_data;
                out_sat_q   <= req_sat;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
